tagged_demultiplexer: RTL and testbench
=======================================

// Module: tagged_demultiplexer
// PURPOSE
// - Splits one tagged stream into NUM_OUTPUTS untagged streams; element goes to out[tag].
// - Producer-side counterpart of the tagged multiplexer: fans work out to per-lane consumers.
// - Optionally broadcasts end-of-stream, so every lane sees exactly one last per input stream.
// PARAMETERS
// - data_t         (none)  payload type carried on in/out
// - NUM_OUTPUTS    4       number of output lanes, >= 2
// - TAG_WIDTH      2       tag width; >= $clog2(NUM_OUTPUTS)
// - LAST_HANDLING  1       0: BROADCAST last to all lanes; 1: FORWARD last to target lane only
// - FILTER_KEEP    1       0: forward keep=0 elements; 1: consume keep=0 elements without output
// PORTS
// - clk        in   1                   clock, all state on rising edge
// - rst_n      in   1                   asynchronous active-low reset
// - in         in   tagged_i.s          data, keep, last, tag[TAG_WIDTH], valid / ready
// - out[N]     out  data_i.m x N        data, keep, last, valid / ready
// - drop_count out  32                  only with TAGGED_DEMUX_STATS_EN, see CONFIGURATION
// BEHAVIOUR
// - Reset: all out[i].valid=0, pending mask=0, state ROUTE, drop_count=0, in.ready=0 during reset.
// - Each lane has a 2-entry skid buffer. Latency is 1 cycle from in handshake to out[i].valid.
//   Full throughput is 1 element/cycle when the target lane drains.
// - Ready rule (ROUTE state): in.ready = target lane has space, OR the element is consumed
//   without output. No combinational path from in.valid to in.ready.
// - Tag range: tag >= NUM_OUTPUTS means the element is consumed (ready=1) and dropped.
//   A dropped element with last set is still treated as last.
// - Keep rule: with FILTER_KEEP=1, keep=0 & last=0 is consumed (ready=1) and not forwarded.
// - Ordering: per-lane order matches input order. No reordering across lanes is visible.
// - FORWARD (LAST_HANDLING=1):
//   - Last goes to the target lane unchanged.
//   - A filtered or dropped last element is lost.
// - BROADCAST (LAST_HANDLING=0), FSM:
//   - ROUTE: on handshake of a last element, enqueue in every lane with space in the same cycle.
//     - Target lane gets the real element with last=1. It gets keep=0 if filtered.
//     - Every other lane gets a dummy: keep=0, last=1, data=0.
//     - pending <= lanes that had no space. If pending != 0, go to BCAST.
//   - Handshake of the last in ROUTE needs no lane space; the missing lanes are covered by pending.
//   - BCAST: in.ready=0. Each cycle, enqueue the owed item into every pending lane with space,
//     then clear its bit. When pending becomes 0, go to ROUTE; in.ready may rise next cycle.
//   - Pending lanes receive the real/dummy item latched at accept time.
// - out[i] holds data/keep/last/valid stable while valid & !ready.
// - Reset mid-BCAST: pending cleared; undelivered dummies are lost; buffers are emptied.
// CONFIGURATION
// - TAGGED_DEMUX_STATS_EN defined:
//   - drop_count port exists. It counts out-of-range-tag handshakes and saturates at 2^32-1.
//   - Filtered keep=0 elements are not counted.
// - TAGGED_DEMUX_STATS_EN undefined: port and counter absent; drops are silent.
// TESTING
// - N=4, tags 0,1,2,3,0, all ready -> out0 gets e0,e4; out1 e1; out2 e2; out3 e3; each 1 cycle later.
// - out1.ready=0, 3 elements tag=1 -> 2 buffered, then in.ready=0; release -> 3 delivered in order.
// - BROADCAST: last on tag=2, out3.ready=0 -> out2 real last; out0, out1 dummy;
//   in.ready=0 until out3.ready=1, then out3 dummy and ROUTE.
// - FORWARD: last on tag=1 -> only out1.last=1; no dummies; next element accepted the next cycle.
// - tag=5 (TAG_WIDTH=3), N=4, x3 -> all consumed; no out valid; drop_count=3 with STATS_EN.
// - FILTER_KEEP=1: keep=0 last=0 consumed silently; keep=0 last=1 in BROADCAST -> 4 lanes last, keep=0.
// - Assert rst_n mid-BCAST -> all valid=0 and pending=0 immediately; stream resumes in ROUTE.

Source files
------------

// File: rtl/tagged_demultiplexer_if.sv
// Stream interfaces for the tagged demultiplexer: tagged input stream and untagged lane stream.
interface tagged_i #(
    parameter type         data_t    = logic [7:0],
    parameter int unsigned TAG_WIDTH = 2
);
    data_t                data;
    logic                 keep;
    logic                 last;
    logic [TAG_WIDTH-1:0] tag;
    logic                 valid;
    logic                 ready;

    modport m (output data, keep, last, tag, valid, input ready);
    modport s (input data, keep, last, tag, valid, output ready);
endinterface

interface data_i #(
    parameter type data_t = logic [7:0]
);
    data_t data;
    logic  keep;
    logic  last;
    logic  valid;
    logic  ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_demultiplexer.sv
// Splits one tagged stream into NUM_OUTPUTS lanes, each with a 2-entry skid buffer.
// Optional drop counter enabled by defining TAGGED_DEMUX_STATS_EN.
module tagged_demultiplexer #(
    parameter type         data_t        = logic [7:0],
    parameter int unsigned NUM_OUTPUTS   = 4,
    parameter int unsigned TAG_WIDTH     = 2,
    parameter int unsigned LAST_HANDLING = 1,
    parameter int unsigned FILTER_KEEP   = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    tagged_i.s    in,
    data_i.m      out [NUM_OUTPUTS]
`ifdef TAGGED_DEMUX_STATS_EN
    ,
    output logic [31:0] drop_count
`endif
);

    localparam int unsigned TAG_EXT_W = TAG_WIDTH + 1;
    localparam logic        BCAST_LAST = (LAST_HANDLING == 0);
    localparam logic        FILTER_EN  = (FILTER_KEEP != 0);

    typedef struct packed {
        data_t data;
        logic  keep;
        logic  last;
    } item_t;

    typedef enum logic {ROUTE, BCAST} state_t;

    localparam item_t DUMMY = '{data: '0, keep: 1'b0, last: 1'b1};

    state_t                 state_q, state_d;
    logic                   run_q;
    logic [NUM_OUTPUTS-1:0] pending_q, pending_d;
    item_t                  owed_q, owed_d;
    logic [NUM_OUTPUTS-1:0] owed_tgt_q, owed_tgt_d;
    logic [NUM_OUTPUTS-1:0] space, lane_hit, push_c;
    item_t                  push_item [NUM_OUTPUTS];
    item_t                  in_item;
    logic                   drop_c, filt_c, bcast_last_c, consume_c, fire_c;

    assign in_item      = '{data: in.data, keep: in.keep, last: in.last};
    assign drop_c       = {1'b0, in.tag} >= TAG_EXT_W'(NUM_OUTPUTS);
    assign filt_c       = FILTER_EN && !in.keep;
    assign bcast_last_c = BCAST_LAST && in.last;
    // Filtered lasts are only consumed silently when they are not broadcast.
    assign consume_c    = drop_c || (filt_c && !bcast_last_c);

    always_comb begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            lane_hit[i] = !drop_c && (in.tag == TAG_WIDTH'(i));
        end
    end

    // Ready depends only on registered state and the tag/keep/last fields, never on valid.
    assign in.ready = run_q && (state_q == ROUTE) &&
                      (bcast_last_c || consume_c || ((lane_hit & space) != '0));
    assign fire_c   = in.valid && in.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ROUTE;
            run_q      <= 1'b0;
            pending_q  <= '0;
            owed_q     <= '0;
            owed_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            pending_q  <= pending_d;
            owed_q     <= owed_d;
            owed_tgt_q <= owed_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        owed_d     = owed_q;
        owed_tgt_d = owed_tgt_q;
        push_c     = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            push_item[i] = DUMMY;
        end
        case (state_q)
            ROUTE: begin
                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    if (lane_hit[i]) push_item[i] = in_item;
                end
                if (fire_c) begin
                    if (bcast_last_c) begin
                        push_c     = space;
                        pending_d  = ~space;
                        owed_d     = in_item;
                        owed_tgt_d = lane_hit;
                        if ((~space) != '0) state_d = BCAST;
                    end else if (!consume_c) begin
                        push_c = lane_hit;
                    end
                end
            end
            BCAST: begin
                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    if (owed_tgt_q[i]) push_item[i] = owed_q;
                end
                push_c    = pending_q & space;
                pending_d = pending_q & ~space;
                if (pending_d == '0) state_d = ROUTE;
            end
            default: state_d = ROUTE;
        endcase
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_lane
        item_t       slot0_q, slot1_q;
        logic [1:0]  cnt_q;
        logic        pop;

        assign pop      = (cnt_q != 2'd0) && out[g].ready;
        assign space[g] = (cnt_q != 2'd2);

        // Skid FIFO: slot0 is the head presented on the lane.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= 2'd0;
                slot0_q <= '0;
                slot1_q <= '0;
            end else if (push_c[g] && pop) begin
                if (cnt_q == 2'd1) begin
                    slot0_q <= push_item[g];
                end else begin
                    slot0_q <= slot1_q;
                    slot1_q <= push_item[g];
                end
            end else if (push_c[g]) begin
                if (cnt_q == 2'd0) slot0_q <= push_item[g];
                else               slot1_q <= push_item[g];
                cnt_q <= cnt_q + 2'd1;
            end else if (pop) begin
                slot0_q <= slot1_q;
                cnt_q   <= cnt_q - 2'd1;
            end
        end

        assign out[g].valid = (cnt_q != 2'd0);
        assign out[g].data  = slot0_q.data;
        assign out[g].keep  = slot0_q.keep;
        assign out[g].last  = slot0_q.last;
    end

`ifdef TAGGED_DEMUX_STATS_EN
    // Saturating count of out-of-range-tag handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (fire_c && drop_c && (drop_count != '1)) begin
            drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tagged_demultiplexer.sv
// Scoreboard bench: a BROADCAST instance (dut 0) and a FORWARD instance (dut 1), TAG_WIDTH=3, N=4.
module tb_tagged_demultiplexer;
    localparam int unsigned N  = 4;
    localparam int unsigned TW = 3;
    typedef logic [7:0] byte_t;
    typedef logic [9:0] item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tagged_i #(.data_t(byte_t), .TAG_WIDTH(TW)) tin_b ();
    tagged_i #(.data_t(byte_t), .TAG_WIDTH(TW)) tin_f ();
    data_i   #(.data_t(byte_t)) ob [N] ();
    data_i   #(.data_t(byte_t)) of [N] ();

    logic [N-1:0] rdy_b = '1, rdy_f = '1;
    logic [N-1:0] vb, vf;
    item_t        ib [N];
    item_t        itf [N];

`ifdef TAGGED_DEMUX_STATS_EN
    logic [31:0] drop_b, drop_f;
`endif

    tagged_demultiplexer #(.data_t(byte_t), .NUM_OUTPUTS(N), .TAG_WIDTH(TW),
                           .LAST_HANDLING(0), .FILTER_KEEP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(tin_b), .out(ob)
`ifdef TAGGED_DEMUX_STATS_EN
        , .drop_count(drop_b)
`endif
    );

    tagged_demultiplexer #(.data_t(byte_t), .NUM_OUTPUTS(N), .TAG_WIDTH(TW),
                           .LAST_HANDLING(1), .FILTER_KEEP(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .in(tin_f), .out(of)
`ifdef TAGGED_DEMUX_STATS_EN
        , .drop_count(drop_f)
`endif
    );

    int checks = 0;
    int fails  = 0;
    item_t exp_q [2][N][$];

    for (genvar g = 0; g < N; g++) begin : g_tap
        assign ob[g].ready = rdy_b[g];
        assign of[g].ready = rdy_f[g];
        assign vb[g]  = ob[g].valid;
        assign vf[g]  = of[g].valid;
        assign ib[g]  = {ob[g].data, ob[g].keep, ob[g].last};
        assign itf[g] = {of[g].data, of[g].keep, of[g].last};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h required=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic mon_pop(input int k, input int i, input item_t got);
        item_t e;
        checks++;
        if (exp_q[k][i].size() == 0) begin
            fails++;
            $display("FAIL unexpected dut%0d lane%0d: got=%h required=none at %0t", k, i, got, $time);
        end else begin
            e = exp_q[k][i].pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL lane_item dut%0d lane%0d: got=%h required=%h at %0t", k, i, got, e, $time);
            end
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_mon
        always @(negedge clk) begin
            if (rst_n) begin
                if (vb[g] && rdy_b[g]) mon_pop(0, g, ib[g]);
                if (vf[g] && rdy_f[g]) mon_pop(1, g, itf[g]);
            end
        end
    end

    task automatic expect_item(input int k, input int i, input byte_t d, input logic kp, input logic l);
        exp_q[k][i].push_back({d, kp, l});
    endtask

    task automatic expect_dummies(input int k, input int skip);
        for (int i = 0; i < N; i++) if (i != skip) expect_item(k, i, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic drive(input int k, input logic v, input logic [TW-1:0] t, input byte_t d,
                         input logic kp, input logic l);
        if (k == 0) begin
            tin_b.valid = v; tin_b.tag = t; tin_b.data = d; tin_b.keep = kp; tin_b.last = l;
        end else begin
            tin_f.valid = v; tin_f.tag = t; tin_f.data = d; tin_f.keep = kp; tin_f.last = l;
        end
    endtask

    function automatic logic in_ready(input int k);
        return (k == 0) ? tin_b.ready : tin_f.ready;
    endfunction

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input int k, input logic [TW-1:0] t, input byte_t d, input logic kp,
                        input logic l, input int max_wait, output int waited);
        drive(k, 1'b1, t, d, kp, l);
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready(k)) break;
            waited++;
            if (waited > max_wait) begin
                checks++;
                fails++;
                $display("FAIL send_timeout dut%0d: got=no_ready required=ready tag=%0d data=%0h", k, t, d);
                break;
            end
        end
        @(posedge clk);
        #1;
        drive(k, 1'b0, '0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        byte_t d;
        logic [TW-1:0] t;
        drive(0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 8'h00, 1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        chk("rst_ready_b", 32'(tin_b.ready), 32'd0);
        chk("rst_ready_f", 32'(tin_f.ready), 32'd0);
        chk("rst_valid_b", 32'(vb), 32'd0);
        chk("rst_valid_f", 32'(vf), 32'd0);
`ifdef TAGGED_DEMUX_STATS_EN
        chk("rst_drop_b", drop_b, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Tags 0,1,2,3,0 back to back on FORWARD instance, one cycle latency each
        for (int i = 0; i < 5; i++) begin
            t = TW'(i % 4);
            d = 8'h10 + 8'(i);
            expect_item(1, i % 4, d, 1'b1, 1'b0);
            send(1, t, d, 1'b1, 1'b0, 5, w);
            if (i > 0) chk("t1_throughput_wait", 32'(w), 32'd0);
            chk("t1_latency_valid", 32'(vf[i % 4]), 32'd1);
        end
        idle(3);

        // Lane 1 stalled: two buffered, third blocked until release
        rdy_f[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_item(1, 1, 8'h20 + 8'(i), 1'b1, 1'b0);
            send(1, 3'd1, 8'h20 + 8'(i), 1'b1, 1'b0, 5, w);
            chk("t2_buffer_wait", 32'(w), 32'd0);
        end
        drive(1, 1'b1, 3'd1, 8'h22, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("t2_full_ready", 32'(tin_f.ready), 32'd0);
            chk("t2_hold_item", 32'(itf[1]), 32'({8'h20, 1'b1, 1'b0}));
        end
        @(posedge clk); #1;
        rdy_f[1] = 1'b1;
        expect_item(1, 1, 8'h22, 1'b1, 1'b0);
        send(1, 3'd1, 8'h22, 1'b1, 1'b0, 5, w);
        idle(4);

        // FORWARD last goes only to its lane; next element accepted next cycle
        expect_item(1, 1, 8'h30, 1'b1, 1'b1);
        send(1, 3'd1, 8'h30, 1'b1, 1'b1, 5, w);
        chk("t3_last_wait", 32'(w), 32'd0);
        expect_item(1, 2, 8'h31, 1'b1, 1'b0);
        send(1, 3'd2, 8'h31, 1'b1, 1'b0, 5, w);
        chk("t3_next_wait", 32'(w), 32'd0);
        idle(3);

        // Out-of-range tag 5 three times: consumed, nothing forwarded
        for (int i = 0; i < 3; i++) begin
            send(1, 3'd5, 8'h50 + 8'(i), 1'b1, 1'b0, 5, w);
            chk("t4_drop_wait", 32'(w), 32'd0);
            chk("t4_drop_no_valid", 32'(vf), 32'd0);
        end
`ifdef TAGGED_DEMUX_STATS_EN
        idle(1);
        chk("t4_drop_count", drop_f, 32'd3);
`endif

        // Filtered keep=0 elements (last or not) vanish in FORWARD mode
        send(1, 3'd0, 8'h55, 1'b0, 1'b0, 5, w);
        chk("t5_filter_wait", 32'(w), 32'd0);
        send(1, 3'd2, 8'h56, 1'b0, 1'b1, 5, w);
        chk("t5_filter_last_wait", 32'(w), 32'd0);
        chk("t5_filter_no_valid", 32'(vf), 32'd0);
        idle(3);

        // BROADCAST with lane 3 full: real last on lane 2, dummies elsewhere, BCAST until lane 3 drains
        rdy_b[3] = 1'b0;
        expect_item(0, 3, 8'h50, 1'b1, 1'b0);
        send(0, 3'd3, 8'h50, 1'b1, 1'b0, 5, w);
        expect_item(0, 3, 8'h51, 1'b1, 1'b0);
        send(0, 3'd3, 8'h51, 1'b1, 1'b0, 5, w);
        expect_item(0, 2, 8'h40, 1'b1, 1'b1);
        expect_dummies(0, 2);
        send(0, 3'd2, 8'h40, 1'b1, 1'b1, 5, w);
        chk("t6_last_wait", 32'(w), 32'd0);
        drive(0, 1'b1, 3'd0, 8'h41, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_bcast_ready", 32'(tin_b.ready), 32'd0);
        end
        @(posedge clk); #1;
        rdy_b[3] = 1'b1;
        expect_item(0, 0, 8'h41, 1'b1, 1'b0);
        send(0, 3'd0, 8'h41, 1'b1, 1'b0, 6, w);
        chk("t6_resume_wait", 32'(w), 32'd2);
        idle(4);

        // BROADCAST filtered last: all four lanes get last with keep=0
        expect_item(0, 1, 8'h60, 1'b0, 1'b1);
        expect_dummies(0, 1);
        send(0, 3'd1, 8'h60, 1'b0, 1'b1, 5, w);
        send(0, 3'd0, 8'h61, 1'b0, 1'b0, 5, w);
        chk("t7_filter_wait", 32'(w), 32'd0);
        idle(1);

        // BROADCAST dropped last: dummies on every lane
        expect_dummies(0, -1);
        send(0, 3'd5, 8'h62, 1'b1, 1'b1, 5, w);
        chk("t8_drop_last_wait", 32'(w), 32'd0);
`ifdef TAGGED_DEMUX_STATS_EN
        idle(1);
        chk("t8_drop_count", drop_b, 32'd1);
`endif
        idle(3);

        // Reset in the middle of BCAST
        rdy_b[3] = 1'b0;
        send(0, 3'd3, 8'h70, 1'b1, 1'b0, 5, w);
        send(0, 3'd3, 8'h71, 1'b1, 1'b0, 5, w);
        expect_item(0, 0, 8'h72, 1'b1, 1'b1);
        expect_item(0, 1, 8'h00, 1'b0, 1'b1);
        expect_item(0, 2, 8'h00, 1'b0, 1'b1);
        send(0, 3'd0, 8'h72, 1'b1, 1'b1, 5, w);
        drive(0, 1'b1, 3'd0, 8'h73, 1'b1, 1'b0);
        idle(2);
        @(negedge clk);
        chk("t9_bcast_ready", 32'(tin_b.ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t9_rst_valid_b", 32'(vb), 32'd0);
        chk("t9_rst_ready_b", 32'(tin_b.ready), 32'd0);
`ifdef TAGGED_DEMUX_STATS_EN
        chk("t9_rst_drop_b", drop_b, 32'd0);
`endif
        drive(0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_b[3] = 1'b1;
        idle(2);
        expect_item(0, 3, 8'h74, 1'b1, 1'b0);
        send(0, 3'd3, 8'h74, 1'b1, 1'b0, 5, w);
        chk("t9_route_wait", 32'(w), 32'd0);
        chk("t9_route_valid", 32'(vb), 32'b1000);
        idle(10);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                chk($sformatf("drain_dut%0d_lane%0d", k, i), 32'(exp_q[k][i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
